// File: rtl/conv_addr_gen_v2_if.sv
// Tuple stream from the address generator to the fused-block PE array.
// The generator drives the tuple and valid; the consumer drives ready.
interface conv_addr_gen_v2_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] ifm_addr;
  logic [ADDR_W-1:0] flt_addr;
  logic              pad_zero;
  logic              last_pixel;

  modport master (
    output out_valid, ifm_addr, flt_addr, pad_zero, last_pixel,
    input  out_ready
  );

  modport slave (
    input  out_valid, ifm_addr, flt_addr, pad_zero, last_pixel,
    output out_ready
  );
endinterface

// File: rtl/conv_addr_gen_v2.sv
// Conv layer address generator: walks t/oy/ox/ky/kx/cw and emits paired
// IFM/filter word addresses on a valid/ready stream, with zero-padding
// flagging, output-channel tiling over TOTAL_PE and config error detection.
module conv_addr_gen_v2 #(
  parameter int unsigned TOTAL_PE = 16,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DIM_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        kernel_w,
  input  logic [1:0]        stride,
  input  logic [1:0]        pad,
  input  logic [DIM_W-1:0]  ifm_w,
  input  logic [DIM_W-1:0]  ifm_h,
  input  logic [DIM_W-1:0]  ifm_cw,
  input  logic [DIM_W-1:0]  ofm_w,
  input  logic [DIM_W-1:0]  ofm_h,
  input  logic [DIM_W-1:0]  ofm_c,
  input  logic [ADDR_W-1:0] base_ifm,
  input  logic [ADDR_W-1:0] base_flt,
  conv_addr_gen_v2_if.master strm,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  localparam int unsigned SW = DIM_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;
  state_t r_state;

  // latched layer configuration
  logic [3:0]        r_k;
  logic [1:0]        r_stride, r_pad;
  logic [DIM_W-1:0]  r_ifm_w, r_ifm_h, r_ifm_cw, r_ofm_w, r_ofm_h, r_tiles;
  logic [ADDR_W-1:0] r_base_ifm, r_base_flt;

  // loop counters of the tuple currently on the stream
  logic [DIM_W-1:0]  r_t, r_oy, r_ox, r_cw;
  logic [3:0]        r_ky, r_kx;

  // registered stream and status outputs
  logic              r_valid, r_pad_zero, r_last_pixel;
  logic [ADDR_W-1:0] r_ifm_addr, r_flt_addr;
  logic              r_busy, r_done, r_cfg_err;

  logic              w_cfg_bad, w_adv, w_final;
  logic [DIM_W-1:0]  w_tiles;
  logic [DIM_W-1:0]  w_n_t, w_n_oy, w_n_ox, w_n_cw;
  logic [3:0]        w_n_ky, w_n_kx;

  logic [3:0]        w_k;
  logic [1:0]        w_stride, w_pad;
  logic [DIM_W-1:0]  w_ifm_w, w_ifm_h, w_ifm_cw;
  logic [ADDR_W-1:0] w_base_ifm, w_base_flt;

  logic [SW-1:0]     w_iy, w_ix;
  logic              w_pz, w_last;
  logic [ADDR_W-1:0] w_ifm_lin, w_ifm_addr, w_flt_addr;

  assign w_cfg_bad = (kernel_w == 4'd0) | (stride == 2'd0) | (ifm_cw == '0) |
                     (ofm_w == '0) | (ofm_h == '0) | (ofm_c == '0);
  assign w_tiles   = DIM_W'((32'(ofm_c) + TOTAL_PE - 1) / TOTAL_PE);
  assign w_adv     = (r_state == S_RUN) & r_valid & strm.out_ready;

  // Next loop counters: cw innermost, t outermost; w_final marks the last tuple
  always_comb begin
    w_n_t   = r_t;
    w_n_oy  = r_oy;
    w_n_ox  = r_ox;
    w_n_ky  = r_ky;
    w_n_kx  = r_kx;
    w_n_cw  = r_cw;
    w_final = 1'b0;
    if (w_adv) begin
      if (r_cw != r_ifm_cw - DIM_W'(1)) begin
        w_n_cw = r_cw + DIM_W'(1);
      end else begin
        w_n_cw = '0;
        if (r_kx != r_k - 4'd1) begin
          w_n_kx = r_kx + 4'd1;
        end else begin
          w_n_kx = '0;
          if (r_ky != r_k - 4'd1) begin
            w_n_ky = r_ky + 4'd1;
          end else begin
            w_n_ky = '0;
            if (r_ox != r_ofm_w - DIM_W'(1)) begin
              w_n_ox = r_ox + DIM_W'(1);
            end else begin
              w_n_ox = '0;
              if (r_oy != r_ofm_h - DIM_W'(1)) begin
                w_n_oy = r_oy + DIM_W'(1);
              end else begin
                w_n_oy = '0;
                if (r_t != r_tiles - DIM_W'(1)) begin
                  w_n_t = r_t + DIM_W'(1);
                end else begin
                  w_n_t   = '0;
                  w_final = 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

  // Config view for the tuple being registered: live inputs when launching
  // from IDLE (first tuple appears the cycle after start), latched otherwise
  always_comb begin
    if (r_state == S_IDLE) begin
      w_k        = kernel_w;
      w_stride   = stride;
      w_pad      = pad;
      w_ifm_w    = ifm_w;
      w_ifm_h    = ifm_h;
      w_ifm_cw   = ifm_cw;
      w_base_ifm = base_ifm;
      w_base_flt = base_flt;
    end else begin
      w_k        = r_k;
      w_stride   = r_stride;
      w_pad      = r_pad;
      w_ifm_w    = r_ifm_w;
      w_ifm_h    = r_ifm_h;
      w_ifm_cw   = r_ifm_cw;
      w_base_ifm = r_base_ifm;
      w_base_flt = r_base_flt;
    end
  end

  // Tap coordinates and addresses of the next tuple; the MSB of iy/ix is the
  // sign, so a negative tap also fails the unsigned upper-bound compare
  always_comb begin
    w_iy       = SW'(w_n_oy) * SW'(w_stride) + SW'(w_n_ky) - SW'(w_pad);
    w_ix       = SW'(w_n_ox) * SW'(w_stride) + SW'(w_n_kx) - SW'(w_pad);
    w_pz       = w_iy[SW-1] | w_ix[SW-1] |
                 (w_iy >= SW'(w_ifm_h)) | (w_ix >= SW'(w_ifm_w));
    w_ifm_lin  = (ADDR_W'(w_iy) * ADDR_W'(w_ifm_w) + ADDR_W'(w_ix)) *
                 ADDR_W'(w_ifm_cw) + ADDR_W'(w_n_cw);
    w_ifm_addr = w_pz ? '0 : w_base_ifm + w_ifm_lin;
    w_flt_addr = w_base_flt +
                 ((ADDR_W'(w_n_t) * ADDR_W'(w_k) + ADDR_W'(w_n_ky)) * ADDR_W'(w_k) +
                  ADDR_W'(w_n_kx)) * ADDR_W'(w_ifm_cw) + ADDR_W'(w_n_cw);
    w_last     = (w_n_ky == w_k - 4'd1) & (w_n_kx == w_k - 4'd1) &
                 (w_n_cw == w_ifm_cw - DIM_W'(1));
  end

  // Control FSM with registered stream/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_pad_zero   <= 1'b0;
      r_last_pixel <= 1'b0;
      r_ifm_addr   <= '0;
      r_flt_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_t          <= '0;
      r_oy         <= '0;
      r_ox         <= '0;
      r_ky         <= '0;
      r_kx         <= '0;
      r_cw         <= '0;
      r_k          <= '0;
      r_stride     <= '0;
      r_pad        <= '0;
      r_ifm_w      <= '0;
      r_ifm_h      <= '0;
      r_ifm_cw     <= '0;
      r_ofm_w      <= '0;
      r_ofm_h      <= '0;
      r_tiles      <= '0;
      r_base_ifm   <= '0;
      r_base_flt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_bad) begin
              r_state   <= S_ERR;
              r_done    <= 1'b1;
              r_cfg_err <= 1'b1;
            end else begin
              r_state      <= S_RUN;
              r_busy       <= 1'b1;
              r_valid      <= 1'b1;
              r_k          <= kernel_w;
              r_stride     <= stride;
              r_pad        <= pad;
              r_ifm_w      <= ifm_w;
              r_ifm_h      <= ifm_h;
              r_ifm_cw     <= ifm_cw;
              r_ofm_w      <= ofm_w;
              r_ofm_h      <= ofm_h;
              r_tiles      <= w_tiles;
              r_base_ifm   <= base_ifm;
              r_base_flt   <= base_flt;
              r_ifm_addr   <= w_ifm_addr;
              r_flt_addr   <= w_flt_addr;
              r_pad_zero   <= w_pz;
              r_last_pixel <= w_last;
            end
          end
        end
        S_RUN: begin
          if (w_adv) begin
            r_t  <= w_n_t;
            r_oy <= w_n_oy;
            r_ox <= w_n_ox;
            r_ky <= w_n_ky;
            r_kx <= w_n_kx;
            r_cw <= w_n_cw;
            if (w_final) begin
              r_state      <= S_DONE;
              r_valid      <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_ifm_addr   <= '0;
              r_flt_addr   <= '0;
              r_pad_zero   <= 1'b0;
              r_last_pixel <= 1'b0;
            end else begin
              r_ifm_addr   <= w_ifm_addr;
              r_flt_addr   <= w_flt_addr;
              r_pad_zero   <= w_pz;
              r_last_pixel <= w_last;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        S_ERR: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_cfg_err <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign strm.out_valid  = r_valid;
  assign strm.ifm_addr   = r_ifm_addr;
  assign strm.flt_addr   = r_flt_addr;
  assign strm.pad_zero   = r_pad_zero;
  assign strm.last_pixel = r_last_pixel;
  assign busy            = r_busy;
  assign done            = r_done;
  assign cfg_err         = r_cfg_err;
endmodule

// File: tb/tb_conv_addr_gen_v2.sv
// Directed bench for conv_addr_gen_v2: hand-computed spot values plus a
// nested-loop reference of the whole tuple sequence per scenario.
module tb_conv_addr_gen_v2;
  localparam int unsigned TOTAL_PE = 16;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DIM_W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [3:0]        kernel_w = '0;
  logic [1:0]        stride = '0, pad = '0;
  logic [DIM_W-1:0]  ifm_w = '0, ifm_h = '0, ifm_cw = '0;
  logic [DIM_W-1:0]  ofm_w = '0, ofm_h = '0, ofm_c = '0;
  logic [ADDR_W-1:0] base_ifm = '0, base_flt = '0;
  logic              busy, done, cfg_err;

  conv_addr_gen_v2_if #(.ADDR_W(ADDR_W)) strm_if ();

  conv_addr_gen_v2 #(.TOTAL_PE(TOTAL_PE), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .kernel_w(kernel_w), .stride(stride), .pad(pad),
    .ifm_w(ifm_w), .ifm_h(ifm_h), .ifm_cw(ifm_cw),
    .ofm_w(ofm_w), .ofm_h(ofm_h), .ofm_c(ofm_c),
    .base_ifm(base_ifm), .base_flt(base_flt),
    .strm(strm_if.master),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ifm;
    logic [31:0] flt;
    logic        pz;
    logic        lp;
  } tup_t;

  tup_t        exp_q[$];
  tup_t        got_q[$];
  logic [31:0] stall_ifm[$];
  logic [31:0] stall_flt[$];
  int          checks = 0;
  int          errors = 0;
  int          done_gap, bubbles;
  logic        valid_at_done, busy_at_done, err_at_done, timed_out;

  task automatic set_cfg(input int k, input int s, input int p, input int iw, input int ih,
                         input int icw, input int ow, input int oh, input int oc,
                         input logic [31:0] bi, input logic [31:0] bf);
    kernel_w = 4'(k); stride = 2'(s); pad = 2'(p);
    ifm_w = 8'(iw); ifm_h = 8'(ih); ifm_cw = 8'(icw);
    ofm_w = 8'(ow); ofm_h = 8'(oh); ofm_c = 8'(oc);
    base_ifm = bi; base_flt = bf;
  endtask

  // Reference tuple sequence straight from the loop nest
  task automatic build_expected();
    int k, tiles, iy, ix;
    tup_t e;
    exp_q.delete();
    k     = int'(kernel_w);
    tiles = (int'(ofm_c) + TOTAL_PE - 1) / TOTAL_PE;
    for (int t = 0; t < tiles; t++)
      for (int oy = 0; oy < int'(ofm_h); oy++)
        for (int ox = 0; ox < int'(ofm_w); ox++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++)
              for (int cw = 0; cw < int'(ifm_cw); cw++) begin
                iy   = oy * int'(stride) + ky - int'(pad);
                ix   = ox * int'(stride) + kx - int'(pad);
                e.pz = (iy < 0) || (iy >= int'(ifm_h)) || (ix < 0) || (ix >= int'(ifm_w));
                e.ifm = e.pz ? 32'd0 : base_ifm + 32'((iy * int'(ifm_w) + ix) * int'(ifm_cw) + cw);
                e.flt = base_flt + 32'(((t * k + ky) * k + kx) * int'(ifm_cw) + cw);
                e.lp  = (ky == k - 1) && (kx == k - 1) && (cw == int'(ifm_cw) - 1);
                exp_q.push_back(e);
              end
  endtask

  // Pulse start; returns at the sample point of the cycle after acceptance
  task automatic start_layer();
    strm_if.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Consume the stream, optionally stalling at a tuple index or freezing at abort_at
  task automatic capture(input int stall_at, input int stall_len, input int abort_at, input int max_cyc);
    int cyc, last_push, stalls;
    tup_t g;
    got_q.delete(); stall_ifm.delete(); stall_flt.delete();
    cyc = 0; last_push = -1; stalls = 0;
    done_gap = -1; bubbles = 0; timed_out = 1'b1;
    valid_at_done = 1'bx; busy_at_done = 1'bx; err_at_done = 1'bx;
    while (cyc < max_cyc) begin
      if (done) begin
        done_gap = cyc - last_push;
        valid_at_done = strm_if.out_valid;
        busy_at_done  = busy;
        err_at_done   = cfg_err;
        timed_out = 1'b0;
        break;
      end
      if (abort_at >= 0 && got_q.size() == abort_at && strm_if.out_valid) begin
        strm_if.out_ready = 1'b0;
        timed_out = 1'b0;
        break;
      end
      if (strm_if.out_valid) begin
        if (got_q.size() == stall_at && stalls < stall_len) begin
          strm_if.out_ready = 1'b0;
          stall_ifm.push_back(strm_if.ifm_addr);
          stall_flt.push_back(strm_if.flt_addr);
          stalls++;
        end else begin
          strm_if.out_ready = 1'b1;
          g.ifm = strm_if.ifm_addr; g.flt = strm_if.flt_addr;
          g.pz  = strm_if.pad_zero; g.lp  = strm_if.last_pixel;
          got_q.push_back(g);
          last_push = cyc;
        end
      end else begin
        strm_if.out_ready = 1'b1;
        if (got_q.size() > 0) bubbles++;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({strm_if.out_valid, strm_if.pad_zero, strm_if.last_pixel, busy, done, cfg_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {strm_if.out_valid, strm_if.pad_zero, strm_if.last_pixel, busy, done, cfg_err});
    end
    checks++;
    if ({strm_if.ifm_addr, strm_if.flt_addr} !== 64'd0) begin
      errors++;
      $display("FAIL reset_addr: got ifm=%h flt=%h expected 0/0", strm_if.ifm_addr, strm_if.flt_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({strm_if.out_valid, busy, done} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got valid/busy/done=%b expected 000", {strm_if.out_valid, busy, done});
    end
  endtask

  task automatic test_padding();
    set_cfg(3, 1, 1, 4, 4, 1, 4, 4, 16, 32'h1000, 32'h2000);
    build_expected();
    start_layer();
    checks++;
    if ({strm_if.out_valid, busy} !== 2'b11) begin
      errors++;
      $display("FAIL pad_first_valid: got valid/busy=%b expected 11", {strm_if.out_valid, busy});
    end
    capture(-1, 0, -1, 1000);
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != 144) begin
      errors++;
      $display("FAIL pad_count: got %0d tuples (timeout=%b) expected 144", got_q.size(), timed_out);
    end
    if (got_q.size() >= 9) begin
      checks++;
      if (got_q[0] !== tup_t'{32'h0, 32'h2000, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL pad_t0: got ifm=%h flt=%h pz=%b expected 0/2000/1", got_q[0].ifm, got_q[0].flt, got_q[0].pz);
      end
      checks++;
      if (got_q[4] !== tup_t'{32'h1000, 32'h2004, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL pad_t4: got ifm=%h flt=%h pz=%b expected 1000/2004/0", got_q[4].ifm, got_q[4].flt, got_q[4].pz);
      end
      checks++;
      if (got_q[8].lp !== 1'b1 || got_q[7].lp !== 1'b0) begin
        errors++;
        $display("FAIL pad_last_pixel: got t7=%b t8=%b expected 0/1", got_q[7].lp, got_q[8].lp);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL pad_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_gap != 1 || {valid_at_done, busy_at_done, err_at_done} !== 3'b000) begin
      errors++;
      $display("FAIL pad_done: got gap=%0d valid/busy/err=%b expected 1/000",
               done_gap, {valid_at_done, busy_at_done, err_at_done});
    end
    checks++;
    if (bubbles != 0) begin
      errors++;
      $display("FAIL pad_throughput: got %0d bubbles expected 0", bubbles);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, strm_if.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL pad_done_pulse: got done/valid=%b expected 00", {done, strm_if.out_valid});
    end
  endtask

  task automatic test_stride();
    int npz;
    set_cfg(3, 2, 0, 10, 10, 1, 4, 4, 16, 32'h0, 32'h0);
    build_expected();
    start_layer();
    capture(-1, 0, -1, 1000);
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != 144) begin
      errors++;
      $display("FAIL stride_count: got %0d tuples expected 144", got_q.size());
    end
    if (got_q.size() >= 10) begin
      checks++;
      if (got_q[9].ifm !== 32'd2 || got_q[9].flt !== 32'd0) begin
        errors++;
        $display("FAIL stride_t9: got ifm=%h flt=%h expected 2/0", got_q[9].ifm, got_q[9].flt);
      end
    end
    npz = 0;
    foreach (got_q[i]) if (got_q[i].pz) npz++;
    checks++;
    if (npz != 0) begin
      errors++;
      $display("FAIL stride_no_pad: got %0d pad_zero tuples expected 0", npz);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stride_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_tiling();
    set_cfg(1, 1, 0, 2, 2, 2, 2, 2, 40, 32'h0, 32'h0);
    build_expected();
    start_layer();
    capture(-1, 0, -1, 500);
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != 24) begin
      errors++;
      $display("FAIL tile_count: got %0d tuples expected 24", got_q.size());
    end
    if (got_q.size() >= 17) begin
      checks++;
      if (got_q[8].flt !== 32'd2 || got_q[8].ifm !== 32'd0) begin
        errors++;
        $display("FAIL tile_t8: got flt=%h ifm=%h expected 2/0", got_q[8].flt, got_q[8].ifm);
      end
      checks++;
      if (got_q[16].flt !== 32'd4) begin
        errors++;
        $display("FAIL tile_t16: got flt=%h expected 4", got_q[16].flt);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL tile_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_cfg(3, 1, 1, 4, 4, 1, 4, 4, 16, 32'h1000, 32'h2000);
    build_expected();
    start_layer();
    capture(4, 5, -1, 1000);
    checks++;
    if (stall_ifm.size() != 5) begin
      errors++;
      $display("FAIL bp_stall_len: got %0d stalled samples expected 5", stall_ifm.size());
    end
    foreach (stall_ifm[i]) begin
      checks++;
      if (stall_ifm[i] !== 32'h1000 || stall_flt[i] !== 32'h2004) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ifm=%h flt=%h expected 1000/2004", i, stall_ifm[i], stall_flt[i]);
      end
    end
    checks++;
    if (got_q.size() != 144 || done_gap != 1) begin
      errors++;
      $display("FAIL bp_count: got %0d tuples gap=%0d expected 144/1", got_q.size(), done_gap);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_restart();
    set_cfg(3, 1, 1, 4, 4, 1, 4, 4, 16, 32'h1000, 32'h2000);
    build_expected();
    start_layer();
    capture(-1, 0, 50, 1000);
    checks++;
    if (timed_out !== 1'b0 || got_q.size() != 50) begin
      errors++;
      $display("FAIL rr_prefix: got %0d tuples expected 50", got_q.size());
    end
    // start while busy, stream frozen on tuple 50
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({strm_if.out_valid, busy} !== 2'b11 || strm_if.ifm_addr !== exp_q[50].ifm ||
        strm_if.flt_addr !== exp_q[50].flt) begin
      errors++;
      $display("FAIL rr_start_ignored: got valid/busy=%b ifm=%h flt=%h expected 11/%h/%h",
               {strm_if.out_valid, busy}, strm_if.ifm_addr, strm_if.flt_addr, exp_q[50].ifm, exp_q[50].flt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({strm_if.out_valid, strm_if.pad_zero, strm_if.last_pixel, busy, done, cfg_err} !== 6'b0 ||
        strm_if.ifm_addr !== 32'd0 || strm_if.flt_addr !== 32'd0) begin
      errors++;
      $display("FAIL rr_reset_outputs: got flags=%b ifm=%h flt=%h expected 0",
               {strm_if.out_valid, strm_if.pad_zero, strm_if.last_pixel, busy, done, cfg_err},
               strm_if.ifm_addr, strm_if.flt_addr);
    end
    strm_if.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({done, strm_if.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rr_no_done: got done/valid=%b expected 00", {done, strm_if.out_valid});
    end
    start_layer();
    capture(-1, 0, -1, 1000);
    checks++;
    if (got_q.size() != 144 || done_gap != 1) begin
      errors++;
      $display("FAIL rr_replay_count: got %0d tuples gap=%0d expected 144/1", got_q.size(), done_gap);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_error();
    for (int n = 0; n < 2; n++) begin
      if (n == 0) set_cfg(3, 1, 1, 4, 4, 1, 4, 4, 0, 32'h1000, 32'h2000);
      else        set_cfg(3, 0, 1, 4, 4, 1, 4, 4, 16, 32'h1000, 32'h2000);
      start_layer();
      checks++;
      if ({done, cfg_err, strm_if.out_valid, busy} !== 4'b1100) begin
        errors++;
        $display("FAIL err_pulse[%0d]: got done/err/valid/busy=%b expected 1100", n,
                 {done, cfg_err, strm_if.out_valid, busy});
      end
      @(posedge clk); #1;
      checks++;
      if ({done, cfg_err, strm_if.out_valid, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL err_clear[%0d]: got done/err/valid/busy=%b expected 0000", n,
                 {done, cfg_err, strm_if.out_valid, busy});
      end
    end
  endtask

  initial begin
    strm_if.out_ready = 1'b1;
    test_reset();
    test_padding();
    test_stride();
    test_tiling();
    test_backpressure();
    test_reset_restart();
    test_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
